// File: rtl/input_port_ctrl.sv
// Memory-mapped button input port: per-channel synchronizer and debouncer,
// sticky rising-edge flags with W1C / clear-on-load-read, interrupt mask.
module input_port_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic lvl,
  output logic rise
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          flip;

  // cnt holds mismatches seen so far; the DEBOUNCE_CYCLES-th one flips LVL.
  assign flip = (s2 != lvl) && (cnt == LAST);
  assign rise = flip && !lvl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (flip) begin
        cnt <= '0;
        lvl <= ~lvl;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module input_port_ctrl #(
  parameter int              WIDTH           = 16,
  parameter int              CHANNELS        = 3,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] BASE_ADDR      = 16'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] buttons,
  input  logic [WIDTH-1:0]    addr,
  input  logic [WIDTH-1:0]    data_in,
  input  logic                we,
  input  logic                reading_for_load,
  output logic [WIDTH-1:0]    q,
  output logic                hit,
  output logic                irq
);
  localparam logic [WIDTH-1:0] A_LVL  = BASE_ADDR;
  localparam logic [WIDTH-1:0] A_EDGE = BASE_ADDR + WIDTH'(1);
  localparam logic [WIDTH-1:0] A_MASK = BASE_ADDR + WIDTH'(2);

  logic [CHANNELS-1:0] lvl, rise;
  logic [CHANNELS-1:0] edge_flag, edge_clr, edge_nx, mask;
  logic                sel_lvl, sel_edge, sel_mask;
  logic [WIDTH-1:0]    q_nx;
  logic                unused_data;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    input_port_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk  (clk),
      .reset(reset),
      .btn  (buttons[i]),
      .lvl  (lvl[i]),
      .rise (rise[i])
    );
  end

  assign sel_lvl     = (addr == A_LVL);
  assign sel_edge    = (addr == A_EDGE);
  assign sel_mask    = (addr == A_MASK);
  assign unused_data = ^data_in;

  always_comb begin
    edge_clr = '0;
    if (sel_edge && we)               edge_clr = edge_clr | data_in[CHANNELS-1:0];
    if (sel_edge && reading_for_load) edge_clr = edge_clr | edge_flag;
    // A fresh rise beats any clear landing on the same edge.
    edge_nx = (edge_flag & ~edge_clr) | rise;
    q_nx = '0;
    if (sel_lvl)       q_nx = WIDTH'(lvl);
    else if (sel_edge) q_nx = WIDTH'(edge_flag);
    else if (sel_mask) q_nx = WIDTH'(mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_flag <= '0;
      mask      <= '0;
      q         <= '0;
      hit       <= 1'b0;
      irq       <= 1'b0;
    end else begin
      edge_flag <= edge_nx;
      if (sel_mask && we) mask <= data_in[CHANNELS-1:0];
      q   <= q_nx;
      hit <= sel_lvl | sel_edge | sel_mask;
      irq <= |(edge_flag & mask);
    end
  end
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl: debounce timing, edge flags, mask/irq,
// set-vs-clear priority, unmapped reads and asynchronous reset.
module tb_input_port_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  buttons;
  logic [15:0] addr, data_in, q;
  logic        we, reading_for_load, hit, irq;
  int          n_cmp = 0;
  int          n_err = 0;

  input_port_ctrl #(.WIDTH(16), .CHANNELS(3), .DEBOUNCE_CYCLES(4), .BASE_ADDR(16'hFF00)) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .addr(addr), .data_in(data_in),
    .we(we), .reading_for_load(reading_for_load), .q(q), .hit(hit), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; buttons = '0; addr = '0; data_in = '0; we = 1'b0; reading_for_load = 1'b0;
    #1;
    chk("rst_q", q, 16'h0); chk("rst_hit", {15'b0, hit}, 16'h0); chk("rst_irq", {15'b0, irq}, 16'h0);
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // Press buttons[1]: LVL rises on edge 2+4, visible in q one edge later
    addr = 16'hFF00; buttons = 3'b010;
    cyc(6);  chk("lvl_b1_pre", q, 16'h0000); chk("hit_lvl", {15'b0, hit}, 16'h1);
    cyc(1);  chk("lvl_b1", q, 16'h0002);
    addr = 16'hFF01;
    cyc(1);  chk("edge_b1", q, 16'h0002);
    buttons = 3'b000;
    cyc(8);  addr = 16'hFF00;
    cyc(1);  chk("lvl_b1_fall", q, 16'h0000);
    addr = 16'hFF01;
    cyc(1);  chk("edge_sticky", q, 16'h0002);
    we = 1'b1; data_in = 16'h0002;
    cyc(1);  chk("w1c_prewrite", q, 16'h0002);
    we = 1'b0; data_in = 16'h0;
    cyc(1);  chk("edge_w1c", q, 16'h0000);

    // 3-cycle glitch on buttons[0] is rejected, 4-cycle pulse is accepted
    addr = 16'hFF00; buttons = 3'b001;
    cyc(3);  buttons = 3'b000;
    cyc(10); chk("glitch_lvl", q, 16'h0000);
    addr = 16'hFF01;
    cyc(1);  chk("glitch_edge", q, 16'h0000);
    addr = 16'hFF00; buttons = 3'b001;
    cyc(4);  buttons = 3'b000;
    cyc(3);  chk("pulse4_lvl", q, 16'h0001);
    addr = 16'hFF01;
    cyc(1);  chk("pulse4_edge", q, 16'h0001);
    cyc(6);  reading_for_load = 1'b1;
    cyc(1);  chk("ldrd_pre", q, 16'h0001);
    reading_for_load = 1'b0;
    cyc(1);  chk("ldrd_clr", q, 16'h0000);

    // MASK bit 2, press buttons[2], irq then load-read clears it
    addr = 16'hFF02; we = 1'b1; data_in = 16'h0004;
    cyc(1);  we = 1'b0; data_in = 16'h0;
    cyc(1);  chk("mask_rd", q, 16'h0004); chk("irq_idle", {15'b0, irq}, 16'h0);
    addr = 16'hFF00; buttons = 3'b100;
    cyc(6);  chk("irq_pre", {15'b0, irq}, 16'h0);
    cyc(1);  chk("irq_set", {15'b0, irq}, 16'h1);
    addr = 16'hFF01; reading_for_load = 1'b1;
    cyc(1);  chk("ldrd_edge2", q, 16'h0004); chk("irq_hold", {15'b0, irq}, 16'h1);
    reading_for_load = 1'b0; addr = 16'h0000;
    cyc(1);  chk("irq_clr", {15'b0, irq}, 16'h0); chk("hit_unmapped0", {15'b0, hit}, 16'h0);
    buttons = 3'b000;
    cyc(8);

    // W1C of EDGE[0] on the very edge it sets: set wins
    addr = 16'hFF01; buttons = 3'b001;
    cyc(5);  we = 1'b1; data_in = 16'h0001;
    cyc(1);  chk("setwin_pre", q, 16'h0000);
    we = 1'b0; data_in = 16'h0;
    cyc(1);  chk("set_wins", q, 16'h0001);
    buttons = 3'b000;
    cyc(8);

    // Unmapped read, ignored writes to read-only/unmapped words
    addr = 16'hFF03; we = 1'b1; data_in = 16'hFFFF;
    cyc(1);  chk("unmapped_q", q, 16'h0000); chk("unmapped_hit", {15'b0, hit}, 16'h0);
    addr = 16'hFF00;
    cyc(1);  we = 1'b0; data_in = 16'h0;
    addr = 16'hFF02;
    cyc(1);  chk("mask_kept", q, 16'h0004);
    addr = 16'hFF00;
    cyc(1);  chk("ro_lvl", q, 16'h0000);

    // Reset mid-debounce, then a held button re-qualifies as a fresh press
    buttons = 3'b100;
    cyc(7);  chk("pre_rst_q", q, 16'h0004); chk("pre_rst_hit", {15'b0, hit}, 16'h1);
    chk("pre_rst_irq", {15'b0, irq}, 16'h1);
    buttons = 3'b101;
    cyc(3);  #2 reset = 1'b0;
    #1;
    chk("mid_rst_q", q, 16'h0); chk("mid_rst_hit", {15'b0, hit}, 16'h0);
    chk("mid_rst_irq", {15'b0, irq}, 16'h0);
    cyc(2);  reset = 1'b1;
    cyc(6);  chk("rel_pre", q, 16'h0000);
    cyc(1);  chk("rel_lvl", q, 16'h0005);
    addr = 16'hFF01;
    cyc(1);  chk("rel_edge", q, 16'h0005); chk("rel_irq_mask0", {15'b0, irq}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
